mem_arbiter: RTL and testbench

- Arbitrates the single shared main-memory port between the instruction-cache miss path (I) and the data-cache miss/write-back path (D) in proc_hier.
- Serialises requests, sequences the fixed-latency memory access, and returns data with a one-cycle done pulse.
- Keeps grant counters for the ICacheReq/DCacheReq statistics in the simulation log.
- D has priority; a starvation guard guarantees I progress.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_lat_timer.sv | 28 ++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter between the
// instruction-cache miss path (I) and the data-cache miss/write-back path (D).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arbStateT;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Bits needed to hold values 0..maxVal, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that marks the cycle in which memory read data is
// valid. It stops at zero once the access has been sequenced.
module mem_lat_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic             last
);

    logic [WIDTH-1:0] count;

    // Load on request, otherwise count down towards zero and hold there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single shared memory port between the I and D miss paths.
// D has priority; after STARVE_LIMIT consecutive D grants with I waiting,
// I is forced through. Each grant runs ISSUE -> WAIT -> RESP, and IDLE
// refuses to grant in the cycle right after RESP so requesters can drop req.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT      = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    output logic             i_done,
    output logic [15:0]      i_rdata,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic             d_done,
    output logic [15:0]      d_rdata,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt
);

    localparam int LAT_W = cntWidth(MEM_LAT);
    localparam int STV_W = cntWidth(STARVE_LIMIT);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    arbStateT         state;
    arbStateT         nextState;
    logic             owner;
    logic             wrQ;
    logic [15:0]      addrQ;
    logic [15:0]      wdataQ;
    logic [15:0]      iRdataQ;
    logic [15:0]      dRdataQ;
    logic [STV_W-1:0] starveCnt;
    logic [CNT_W-1:0] iCntQ;
    logic [CNT_W-1:0] dCntQ;
    logic             afterResp;
    logic             grant;
    logic             pickI;
    logic             timerLoad;
    logic             timerLast;
    logic             capture;

    mem_lat_timer #(
        .WIDTH(LAT_W)
    ) latTimer (
        .clk      (clk),
        .rst      (rst),
        .load     (timerLoad),
        .loadValue(LAT_LOAD),
        .last     (timerLast)
    );

    // Arbitration: D wins unless I is waiting and has been starved too long.
    always_comb begin
        grant     = (state == IDLE) && (i_req || d_req) && !afterResp;
        pickI     = i_req && (!d_req || (starveCnt == STARVE_MAX));
        timerLoad = (state == ISSUE);
        capture   = (state == WAIT) && timerLast;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (grant) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT:    if (timerLast) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic: memory strobe and its qualified fields, done pulses.
    always_comb begin
        mem_en    = (state == ISSUE);
        mem_wr    = mem_en && wrQ;
        mem_addr  = mem_en ? addrQ  : 16'h0000;
        mem_wdata = mem_en ? wdataQ : 16'h0000;
        i_done    = (state == RESP) && (owner == OWN_I);
        d_done    = (state == RESP) && (owner == OWN_D);
        busy      = (state != IDLE);
    end

    // Remember that the previous cycle was RESP to enforce the IDLE gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            afterResp <= 1'b0;
        end else begin
            afterResp <= (state == RESP);
        end
    end

    // Latch the winner's request so later changes on its inputs are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner  <= OWN_I;
            wrQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else if (grant) begin
            owner  <= pickI ? OWN_I : OWN_D;
            wrQ    <= pickI ? 1'b0 : d_wr;
            addrQ  <= pickI ? i_addr : d_addr;
            wdataQ <= pickI ? 16'h0000 : d_wdata;
        end
    end

    // Starvation tracking: count D grants taken while I waits, clear on I.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= '0;
        end else if (grant) begin
            if (pickI) begin
                starveCnt <= '0;
            end else if (i_req && (starveCnt != STARVE_MAX)) begin
                starveCnt <= starveCnt + 1'b1;
            end
        end
    end

    // Saturating grant statistics per requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iCntQ <= '0;
            dCntQ <= '0;
        end else if (grant) begin
            if (pickI && (iCntQ != '1)) begin
                iCntQ <= iCntQ + 1'b1;
            end
            if (!pickI && (dCntQ != '1)) begin
                dCntQ <= dCntQ + 1'b1;
            end
        end
    end

    // Capture read data for the owner; D writes leave d_rdata untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iRdataQ <= '0;
            dRdataQ <= '0;
        end else if (capture) begin
            if (owner == OWN_I) begin
                iRdataQ <= mem_rdata;
            end else if (!wrQ) begin
                dRdataQ <= mem_rdata;
            end
        end
    end

    assign i_rdata     = iRdataQ;
    assign d_rdata     = dRdataQ;
    assign i_grant_cnt = iCntQ;
    assign d_grant_cnt = dCntQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance A uses default parameters, instance B uses
// MEM_LAT=1 and CNT_W=2. A behavioural memory returns addr^0xBEAF exactly
// MEM_LAT cycles after mem_en and 0xDEAD otherwise; expected completions are
// queued when a request is driven and popped when the matching done pulses.
module tb_mem_arbiter;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    typedef struct {
        logic [15:0] data;
        int          cycle;
    } expT;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        aIReq, aDReq, aDWr, aIDone, aDDone, aMemEn, aMemWr, aBusy;
    logic [15:0] aIAddr, aDAddr, aDWdata, aIRdata, aDRdata, aMemAddr, aMemWdata, aMemRdata;
    logic [15:0] aICnt, aDCnt;
    logic        bIReq, bDReq, bDWr, bIDone, bDDone, bMemEn, bMemWr, bBusy;
    logic [15:0] bIAddr, bDAddr, bDWdata, bIRdata, bDRdata, bMemAddr, bMemWdata, bMemRdata;
    logic [1:0]  bICnt, bDCnt;

    expT aIQ[$];
    expT aDQ[$];
    expT bIQ[$];
    expT bDQ[$];
    logic [15:0] aLastDRead = 16'h0000;
    logic [15:0] bLastDRead = 16'h0000;
    int          bLastDoneCyc = -1;

    always #5 clk = ~clk;

    // Cycle index used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.MEM_LAT(LAT_A), .STARVE_LIMIT(3), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst),
        .i_req(aIReq), .i_addr(aIAddr), .i_done(aIDone), .i_rdata(aIRdata),
        .d_req(aDReq), .d_wr(aDWr), .d_addr(aDAddr), .d_wdata(aDWdata),
        .d_done(aDDone), .d_rdata(aDRdata),
        .mem_en(aMemEn), .mem_wr(aMemWr), .mem_addr(aMemAddr), .mem_wdata(aMemWdata),
        .mem_rdata(aMemRdata), .busy(aBusy),
        .i_grant_cnt(aICnt), .d_grant_cnt(aDCnt)
    );

    mem_arbiter #(.MEM_LAT(LAT_B), .STARVE_LIMIT(3), .CNT_W(2)) dutB (
        .clk(clk), .rst(rst),
        .i_req(bIReq), .i_addr(bIAddr), .i_done(bIDone), .i_rdata(bIRdata),
        .d_req(bDReq), .d_wr(bDWr), .d_addr(bDAddr), .d_wdata(bDWdata),
        .d_done(bDDone), .d_rdata(bDRdata),
        .mem_en(bMemEn), .mem_wr(bMemWr), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
        .mem_rdata(bMemRdata), .busy(bBusy),
        .i_grant_cnt(bICnt), .d_grant_cnt(bDCnt)
    );

    function automatic logic [15:0] memModel(input logic [15:0] a);
        return a ^ 16'hBEAF;
    endfunction

    // Memory model A: data is valid only MEM_LAT cycles after mem_en.
    logic [LAT_A-1:0] aPipeV = '0;
    logic [15:0]      aPipeAddr [LAT_A];
    always @(posedge clk) begin
        aPipeV       <= {aPipeV[LAT_A-2:0], aMemEn};
        aPipeAddr[0] <= aMemAddr;
        for (int k = 1; k < LAT_A; k++) aPipeAddr[k] <= aPipeAddr[k-1];
    end
    assign aMemRdata = aPipeV[LAT_A-1] ? memModel(aPipeAddr[LAT_A-1]) : 16'hDEAD;

    // Memory model B: single-cycle latency.
    logic        bPipeV = 1'b0;
    logic [15:0] bPipeAddr = 16'h0000;
    always @(posedge clk) begin
        bPipeV    <= bMemEn;
        bPipeAddr <= bMemAddr;
    end
    assign bMemRdata = bPipeV ? memModel(bPipeAddr) : 16'hDEAD;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop the expectation for each done pulse and compare.
    always @(negedge clk) begin
        expT e;
        if (aIDone) begin
            if (aIQ.size() == 0) checkOutput("aI_spurious_done", 32'(aIDone), 32'd0);
            else begin
                e = aIQ.pop_front();
                checkOutput("aI_rdata", 32'(aIRdata), 32'(e.data));
                if (e.cycle >= 0) checkOutput("aI_done_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
        if (aDDone) begin
            if (aDQ.size() == 0) checkOutput("aD_spurious_done", 32'(aDDone), 32'd0);
            else begin
                e = aDQ.pop_front();
                checkOutput("aD_rdata", 32'(aDRdata), 32'(e.data));
                if (e.cycle >= 0) checkOutput("aD_done_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
        if (bIDone) begin
            if (bIQ.size() == 0) checkOutput("bI_spurious_done", 32'(bIDone), 32'd0);
            else begin
                e = bIQ.pop_front();
                checkOutput("bI_rdata", 32'(bIRdata), 32'(e.data));
                if (e.cycle >= 0) checkOutput("bI_done_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
        if (bDDone) begin
            if (bDQ.size() == 0) checkOutput("bD_spurious_done", 32'(bDDone), 32'd0);
            else begin
                e = bDQ.pop_front();
                checkOutput("bD_rdata", 32'(bDRdata), 32'(e.data));
                if (e.cycle >= 0) checkOutput("bD_done_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
        if (bMemEn && (bLastDoneCyc >= 0)) checkOutput("b_idle_gap_ge2", 32'((cyc - bLastDoneCyc) >= 2), 32'd1);
        if (bIDone || bDDone) bLastDoneCyc = cyc;
    end

    // One complete access on instance A or B, with issue-cycle checks.
    task automatic applyStimulus(input bit onB, input bit isD, input bit wr,
                                 input logic [15:0] addr, input logic [15:0] wdata, input string tag);
        int          startCyc;
        int          lat;
        logic [15:0] expData;
        bit          seen;
        lat = onB ? LAT_B : LAT_A;
        @(negedge clk);
        startCyc = cyc;
        if (isD && wr) expData = onB ? bLastDRead : aLastDRead;
        else           expData = memModel(addr);
        if (isD && !wr) begin
            if (onB) bLastDRead = expData;
            else     aLastDRead = expData;
        end
        if (!onB) begin
            if (isD) begin aDQ.push_back('{expData, startCyc + lat + 2}); aDReq = 1; aDWr = wr; aDAddr = addr; aDWdata = wdata; end
            else     begin aIQ.push_back('{expData, startCyc + lat + 2}); aIReq = 1; aIAddr = addr; end
        end else begin
            if (isD) begin bDQ.push_back('{expData, startCyc + lat + 2}); bDReq = 1; bDWr = wr; bDAddr = addr; bDWdata = wdata; end
            else     begin bIQ.push_back('{expData, startCyc + lat + 2}); bIReq = 1; bIAddr = addr; end
        end
        @(negedge clk);
        checkOutput({tag, "_mem_en"},   32'(onB ? bMemEn : aMemEn), 32'd1);
        checkOutput({tag, "_mem_addr"}, 32'(onB ? bMemAddr : aMemAddr), 32'(addr));
        checkOutput({tag, "_mem_wr"},   32'(onB ? bMemWr : aMemWr), 32'(isD && wr));
        if (isD) checkOutput({tag, "_mem_wdata"}, 32'(onB ? bMemWdata : aMemWdata), 32'(wdata));
        @(negedge clk);
        checkOutput({tag, "_mem_en_off"},   32'(onB ? bMemEn : aMemEn), 32'd0);
        checkOutput({tag, "_mem_addr_off"}, 32'(onB ? bMemAddr : aMemAddr), 32'd0);
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (onB) seen = isD ? bDDone : bIDone;
            else     seen = isD ? aDDone : aIDone;
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        if (onB) begin bIReq = 0; bDReq = 0; end
        else     begin aIReq = 0; aDReq = 0; end
    endtask

    initial begin
        logic [7:0] order;
        bit         seen;
        bit         winner;
        bit         sawDone;

        rst = 0;
        aIReq = 0; aDReq = 0; aDWr = 0; aIAddr = 0; aDAddr = 0; aDWdata = 0;
        bIReq = 0; bDReq = 0; bDWr = 0; bIAddr = 0; bDAddr = 0; bDWdata = 0;
        #1;
        checkOutput("reset_busy",   32'(aBusy), 32'd0);
        checkOutput("reset_mem_en", 32'(aMemEn), 32'd0);
        checkOutput("reset_icnt",   32'(aICnt), 32'd0);
        checkOutput("reset_dcnt",   32'(aDCnt), 32'd0);
        checkOutput("reset_irdata", 32'(aIRdata), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1;

        $display("[TB] I read, default latency");
        applyStimulus(0, 0, 0, 16'h0040, 16'h0000, "iread");
        checkOutput("iread_icnt", 32'(aICnt), 32'd1);

        $display("[TB] D read then D write");
        applyStimulus(0, 1, 0, 16'h0500, 16'h0000, "dread");
        applyStimulus(0, 1, 1, 16'h1000, 16'h1234, "dwrite");
        checkOutput("dwrite_dcnt", 32'(aDCnt), 32'd2);

        $display("[TB] starvation guard, both requests held");
        order = 8'b1110_1110;
        @(negedge clk);
        aIReq = 1; aIAddr = 16'h0300; aDReq = 1; aDWr = 0; aDAddr = 16'h0400;
        aLastDRead = memModel(16'h0400);
        for (int g = 0; g < 8; g++) begin
            if (order[7-g]) aDQ.push_back('{memModel(16'h0400), -1});
            else            aIQ.push_back('{memModel(16'h0300), -1});
        end
        for (int g = 0; g < 8; g++) begin
            seen = 0; winner = 0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                if (aIDone || aDDone) begin seen = 1; winner = aDDone; end
            end
            checkOutput($sformatf("starve_grant%0d_seen", g), 32'(seen), 32'd1);
            checkOutput($sformatf("starve_grant%0d_isD", g), 32'(winner), 32'(order[7-g]));
        end
        @(negedge clk);
        aIReq = 0; aDReq = 0;
        @(negedge clk);
        checkOutput("starve_icnt", 32'(aICnt), 32'd3);
        checkOutput("starve_dcnt", 32'(aDCnt), 32'd8);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        aIReq = 1; aIAddr = 16'h0080;
        repeat (3) @(negedge clk);
        checkOutput("rstwait_busy_before", 32'(aBusy), 32'd1);
        rst = 0;
        #1;
        checkOutput("rstwait_busy",   32'(aBusy), 32'd0);
        checkOutput("rstwait_icnt",   32'(aICnt), 32'd0);
        checkOutput("rstwait_dcnt",   32'(aDCnt), 32'd0);
        checkOutput("rstwait_irdata", 32'(aIRdata), 32'd0);
        checkOutput("rstwait_drdata", 32'(aDRdata), 32'd0);
        aLastDRead = 16'h0000;
        @(negedge clk);
        aIReq = 0;
        @(negedge clk);
        rst = 1;
        sawDone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (aIDone || aDDone) sawDone = 1;
        end
        checkOutput("rstwait_no_done", 32'(sawDone), 32'd0);
        applyStimulus(0, 0, 0, 16'h0040, 16'h0000, "post_rst");
        checkOutput("post_rst_icnt", 32'(aICnt), 32'd1);

        $display("[TB] MEM_LAT=1 back-to-back D reads with held request");
        @(negedge clk);
        bDQ.push_back('{memModel(16'h0100), cyc + 3});
        bDQ.push_back('{memModel(16'h0200), cyc + 8});
        bLastDRead = memModel(16'h0200);
        bDReq = 1; bDWr = 0; bDAddr = 16'h0100;
        @(negedge clk);
        checkOutput("b2b_mem_addr", 32'(bMemAddr), 32'h0100);
        @(negedge clk);
        bDAddr = 16'h0200;
        seen = 0;
        for (int n = 0; n < 40 && bDQ.size() != 0; n++) @(negedge clk);
        checkOutput("b2b_both_done", 32'(bDQ.size()), 32'd0);
        @(negedge clk);
        bDReq = 0;
        checkOutput("b2b_dcnt", 32'(bDCnt), 32'd2);

        $display("[TB] counter saturation on CNT_W=2");
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 16'(16'h0020 + k), 16'h0000, "bsat");
        checkOutput("bsat_icnt", 32'(bICnt), 32'd3);
        checkOutput("bsat_dcnt", 32'(bDCnt), 32'd2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
